garage_door_input_conditioner: RTL and testbench

GARAGE_DOOR_INPUT_CONDITIONER -- requirements
Module: garage_door_input_conditioner

---
 rtl/garage_door_input_conditioner_pkg.sv | 22 ++
 rtl/garage_door_input_conditioner_if.sv | 17 +
 rtl/gd_debounce_cell.sv | 42 ++++
 rtl/garage_door_input_conditioner.sv | 114 +++++++++++
 tb/tb_garage_door_input_conditioner.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/garage_door_input_conditioner_pkg.sv
// Shared types and constants for the garage door input conditioner.
//   CNT_W              width of every debounce/holdoff/fault counter
//   *_DEF              default cycle counts for the conditioner parameters
//   holdoff_state_e    button holdoff FSM states
//   min1()             clamps a cycle-count parameter to at least 1
package garage_door_pkg;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] DB_CYCLES_DEF      = 16'd50000;
  // 100000 cycles does not fit the 16-bit counter; use the largest count.
  localparam logic [CNT_W-1:0] HOLDOFF_CYCLES_DEF = 16'hFFFF;
  localparam logic [CNT_W-1:0] FAULT_CYCLES_DEF   = 16'd1000;

  typedef enum logic {
    READY   = 1'b0,
    HOLDOFF = 1'b1
  } holdoff_state_e;

  function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction
endpackage

// File: rtl/garage_door_input_conditioner_if.sv
// Raw switch inputs and conditioned outputs of the garage door conditioner.
//   master : board/test side, drives the raw inputs, observes the outputs
//   slave  : conditioner side
interface garage_door_input_conditioner_if;
  logic BTN_RAW;
  logic UP_LIM_RAW;
  logic DN_LIM_RAW;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic LIM_FAULT;

  modport master (output BTN_RAW, UP_LIM_RAW, DN_LIM_RAW,
                  input  Activate, UP_Max, DN_Max, LIM_FAULT);
  modport slave  (input  BTN_RAW, UP_LIM_RAW, DN_LIM_RAW,
                  output Activate, UP_Max, DN_Max, LIM_FAULT);
endinterface

// File: rtl/gd_debounce_cell.sv
// One debounced input channel: 2-flop synchronizer, saturating run counter
// and the accepted (stable) level.
//   CLK, RST (async, active-low)
//   raw   : asynchronous bouncy input
//   level : debounced level; toggles after the synchronized input has
//           disagreed with it on DB_CYCLES+1 consecutive edges
module gd_debounce_cell
  import garage_door_pkg::*;
#(
  parameter logic [CNT_W-1:0] DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level
);
  localparam logic [CNT_W-1:0] DB_N = min1(DB_CYCLES);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt >= DB_N) begin
        // counter already holds DB_CYCLES: accept the new level this edge
        level <= ~level;
        cnt   <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/garage_door_input_conditioner.sv
// Garage door input conditioner: debounces the button and both limit
// switches, turns a debounced button rise into a one-cycle Activate pulse and
// ignores further presses for HOLDOFF_CYCLES afterwards.
//   CLK, RST (async, active-low)
//   io.BTN_RAW/UP_LIM_RAW/DN_LIM_RAW : raw asynchronous inputs
//   io.Activate  : one-cycle door request
//   io.UP_Max/DN_Max : debounced limit levels (never gated)
//   io.LIM_FAULT : sticky "both limits active" flag
// Build option: define GARAGE_LIMIT_FAULT_EN to include the limit fault
// detector; otherwise LIM_FAULT is tied low and Activate is never blocked.
module garage_door_input_conditioner
  import garage_door_pkg::*;
#(
  parameter logic [CNT_W-1:0] DB_CYCLES      = DB_CYCLES_DEF,
  parameter logic [CNT_W-1:0] HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter logic [CNT_W-1:0] FAULT_CYCLES   = FAULT_CYCLES_DEF
) (
  input  logic                            CLK,
  input  logic                            RST,
  garage_door_input_conditioner_if.slave  io
);
  localparam int NUM_CH = 3;
  localparam logic [CNT_W-1:0] HOLD_LAST = min1(HOLDOFF_CYCLES) - CNT_W'(1);

  // channel 0 = button, 1 = upper limit, 2 = lower limit
  logic [NUM_CH-1:0] raw_v, lvl_v;
  assign raw_v = {io.DN_LIM_RAW, io.UP_LIM_RAW, io.BTN_RAW};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gd_debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLK   (CLK),
      .RST   (RST),
      .raw   (raw_v[g]),
      .level (lvl_v[g])
    );
  end

  assign io.UP_Max = lvl_v[1];
  assign io.DN_Max = lvl_v[2];

  logic fault_d;  // fault state as of the coming edge

`ifdef GARAGE_LIMIT_FAULT_EN
  localparam logic [CNT_W-1:0] FAULT_LAST = min1(FAULT_CYCLES) - CNT_W'(1);
  logic             fault_q;
  logic [CNT_W-1:0] fcnt;
  logic             both_lim;

  assign both_lim = lvl_v[1] & lvl_v[2];
  // include the setting edge so Activate never coincides with LIM_FAULT
  assign fault_d  = fault_q | (both_lim & (fcnt >= FAULT_LAST));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fcnt    <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
      if (!both_lim)                            fcnt <= '0;
      else if (fcnt < FAULT_LAST && fcnt != '1) fcnt <= fcnt + CNT_W'(1);
    end
  end
  assign io.LIM_FAULT = fault_q;
`else
  assign fault_d      = 1'b0;
  // FAULT_CYCLES stays referenced so both builds share one parameter list
  assign io.LIM_FAULT = 1'b0 && (FAULT_CYCLES != '0);
`endif

  // button rise detect, holdoff FSM and registered Activate
  holdoff_state_e   st, st_d;
  logic [CNT_W-1:0] hcnt, hcnt_d;
  logic             btn_q, act_q, act_d, btn_rise;

  assign btn_rise    = lvl_v[0] & ~btn_q;
  assign io.Activate = act_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st    <= READY;
      hcnt  <= '0;
      btn_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      st    <= st_d;
      hcnt  <= hcnt_d;
      btn_q <= lvl_v[0];
      act_q <= act_d;
    end
  end

  always_comb begin
    st_d   = st;
    hcnt_d = hcnt;
    act_d  = 1'b0;
    case (st)
      READY: begin
        hcnt_d = '0;
        if (act_q) st_d = HOLDOFF;
        else       act_d = btn_rise & ~fault_d;
      end
      HOLDOFF: begin
        // rises seen here (including on the exit edge) are dropped
        if (hcnt >= HOLD_LAST) begin
          st_d   = READY;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt + CNT_W'(1);
        end
      end
      default: st_d = READY;
    endcase
  end
endmodule

// File: tb/tb_garage_door_input_conditioner.sv
// Self-checking bench for garage_door_input_conditioner (DB=4, HOLDOFF=10,
// FAULT=8): directed scenarios followed by randomized run-length stimulus,
// compared every cycle against a timestamp/window reference model.
module tb_garage_door_input_conditioner;
  import garage_door_pkg::*;

  localparam int DB = 4, HO = 10, FC = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  garage_door_input_conditioner_if io();

  garage_door_input_conditioner #(
    .DB_CYCLES      (16'(DB)),
    .HOLDOFF_CYCLES (16'(HO)),
    .FAULT_CYCLES   (16'(FC))
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (io.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;
  int n_act = 0;

`ifdef GARAGE_LIMIT_FAULT_EN
  localparam bit FAULT_ON = 1'b1;
`else
  localparam bit FAULT_ON = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Each channel's accepted level flips once the last DB+1 values it has seen
  // (raw delayed two edges) all disagree with it. Activate = debounced rise,
  // at least HO+2 edges after the previous Activate, and no fault.
  logic [2:0] d1, d2;
  logic [2:0] win[$];
  logic [2:0] m_st, m_st_p;
  int         t, last_act, run;
  logic       m_act, m_fault;

  task automatic model_reset();
    d1 = '0; d2 = '0; win.delete();
    m_st = '0; m_st_p = '0;
    t = 0; last_act = -1000; run = 0;
    m_act = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] obs, nst;
    logic       rise, all_diff;
    obs = d2; d2 = d1; d1 = raw;
    win.push_back(obs);
    if (win.size() > DB + 1) void'(win.pop_front());
    nst = m_st;
    for (int c = 0; c < 3; c++) begin
      all_diff = (win.size() == DB + 1);
      foreach (win[i]) if (win[i][c] == m_st[c]) all_diff = 1'b0;
      if (all_diff) nst[c] = ~m_st[c];
    end
    rise = m_st[0] & ~m_st_p[0];
    if (m_st[1] & m_st[2]) run++; else run = 0;
    if (FAULT_ON && run >= FC) m_fault = 1'b1;
    m_act = rise && (t - last_act >= HO + 2) && !m_fault;
    if (m_act) last_act = t;
    m_st_p = m_st; m_st = nst; t++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got == exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock: apply raw {dn,up,btn}, step model, sample 1 time unit later
  task automatic cyc(input logic [2:0] raw);
    io.BTN_RAW = raw[0]; io.UP_LIM_RAW = raw[1]; io.DN_LIM_RAW = raw[2];
    @(posedge CLK);
    if (RST) model_edge(raw);
    #1;
    if (io.Activate === 1'b1) n_act++;
    check("activate", io.Activate, m_act);
    check("up_max",   io.UP_Max,   m_st[1]);
    check("dn_max",   io.DN_Max,   m_st[2]);
    check("lim_fault", io.LIM_FAULT, m_fault);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000);
  endtask

  // two button presses: high hi cycles, low lo cycles, high hi, then idle
  task automatic two_press(input int hi, input int lo);
    for (int i = 0; i < hi; i++) cyc(3'b001);
    for (int i = 0; i < lo; i++) cyc(3'b000);
    for (int i = 0; i < hi; i++) cyc(3'b001);
    idle(30);
  endtask

  int cnt_hi;
  logic seen;
  logic [2:0] rnd_lvl;
  int rnd_len[3];

  initial begin
    model_reset();
    io.BTN_RAW = 1'b1; io.UP_LIM_RAW = 1'b1; io.DN_LIM_RAW = 1'b1;

    // reset held with all inputs high: outputs stay low
    for (int i = 0; i < 5; i++) cyc(3'b111);
    RST = 1'b1;
    // limits released after 6 edges so they never overlap long enough to fault
    for (int i = 0; i < 9; i++) begin
      cyc((i < 6) ? 3'b111 : 3'b001);
      if (i == 5) check("rst_up_e5", io.UP_Max, 1'b0);
      if (i == 6) check("rst_up_e6", io.UP_Max, 1'b1);
      if (i == 6) check("rst_act_e6", io.Activate, 1'b0);
      if (i == 7) check("rst_act_e7", io.Activate, 1'b1);
      if (i == 8) check("rst_act_e8", io.Activate, 1'b0);
    end
    idle(30);

    // bounce: toggles every 2 cycles for 12 cycles, then held high
    n_act = 0;
    for (int i = 0; i < 12; i++) cyc(((i / 2) % 2 == 0) ? 3'b001 : 3'b000);
    for (int i = 0; i < 20; i++) begin
      cyc(3'b001);
      if (i == 6) check("bounce_act_e6", io.Activate, 1'b0);
      if (i == 7) check("bounce_act_e7", io.Activate, 1'b1);
    end
    idle(30);  // release must not pulse
    check_int("bounce_pulses", n_act, 1);

    // holdoff: rises 8, 11 (exit edge), 12 and 20 cycles apart
    n_act = 0; two_press(6, 2);  check_int("hold_8apart", n_act, 1);
    n_act = 0; two_press(6, 5);  check_int("hold_11apart", n_act, 1);
    n_act = 0; two_press(6, 6);  check_int("hold_12apart", n_act, 2);
    n_act = 0; two_press(6, 14); check_int("hold_20apart", n_act, 2);

    // glitch on lower limit: 3 cycles ignored, 6 cycles passes for 6 cycles
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(3'b100); seen |= io.DN_Max; end
    for (int i = 0; i < 20; i++) begin cyc(3'b000); seen |= io.DN_Max; end
    check("glitch3_dn", seen, 1'b0);
    cnt_hi = 0;
    for (int i = 0; i < 6; i++) begin cyc(3'b100); cnt_hi += int'(io.DN_Max); end
    for (int i = 0; i < 20; i++) begin cyc(3'b000); cnt_hi += int'(io.DN_Max); end
    check_int("glitch6_dn_cycles", cnt_hi, 6);

    // reset during holdoff: no pulse afterwards
    for (int i = 0; i < 9; i++) cyc(3'b001);
    #2 RST = 1'b0; model_reset();
    #1 check("rst_mid_act", io.Activate, 1'b0);
    cyc(3'b001);
    RST = 1'b1;
    n_act = 0;
    idle(30);
    check_int("rst_mid_pulses", n_act, 0);

    // both limits high for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc(3'b110);
      if (i == 13) check("fault_e13", io.LIM_FAULT, 1'b0);
      if (i == 14) check("fault_e14", io.LIM_FAULT, FAULT_ON);
    end
    idle(30);
    check("fault_sticky", io.LIM_FAULT, FAULT_ON);
    n_act = 0;
    for (int i = 0; i < 10; i++) cyc(3'b001);
    idle(20);
    check_int("fault_blocks_act", n_act, FAULT_ON ? 0 : 1);

    // random run-length stimulus with occasional asynchronous resets
    #2 RST = 1'b0; model_reset();
    cyc(3'b000);
    RST = 1'b1;
    rnd_lvl = '0;
    for (int c = 0; c < 3; c++) rnd_len[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (rnd_len[c] == 0) begin
          rnd_lvl[c] = ~rnd_lvl[c];
          rnd_len[c] = (c == 0) ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 40));
        end
        rnd_len[c]--;
      end
      cyc(rnd_lvl);
      if ($urandom_range(0, 499) == 0) begin
        #2 RST = 1'b0; model_reset();
        cyc(rnd_lvl);
        RST = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
